vl_beat_sequencer: RTL and testbench

- Consumes the committed vector configuration from the config unit: the application vector length `avl` in elements, `sew` (element-width code) and `vill`.
- Walks one vector operand in DATA_WIDTH-wide beats. Each beat produces a beat index, a byte-enable mask and a last flag under a valid/ready handshake.
- Sits between issue and the vector register-file read/write ports. It is the reader side of the vl/vtype state the config unit writes.

---
 rtl/vrvv_cfg_pkg.sv | 23 ++
 rtl/vl_beat_sequencer_be_mask_gen.sv | 24 ++
 rtl/vl_beat_sequencer.sv | 145 ++++++++++++++
 tb/tb_vl_beat_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vrvv_cfg_pkg.sv
// Shared vector-configuration definitions for the vl/vtype reader blocks.
// Holds the SEW encoding, the bytes-per-beat derivation and the
// beat-sequencer state type.
package vrvv_cfg_pkg;

  // Element-width codes as committed by the config unit.
  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;
  localparam logic [1:0] SEW_64 = 2'd3;

  // Bytes carried by one datapath beat.
  function automatic int unsigned dw_bytes(input int unsigned data_width);
    return data_width / 8;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/vl_beat_sequencer_be_mask_gen.sv
// Combinational byte-enable expander: turns the number of bytes remaining
// in an operand into the enable mask for one beat. Low bytes are enabled
// first; any rem >= DW_B yields all ones. Shared with the write-back path.
// Ports:
//   rem  in  REM_W  bytes still to be covered, counting this beat
//   be   out DW_B   byte enables for the beat
module be_mask_gen #(
  parameter int DW_B  = 8,
  parameter int REM_W = 15
) (
  input  logic [REM_W-1:0] rem,
  output logic [DW_B-1:0]  be
);

  // Byte i is live when more than i bytes remain; this is (1<<rem)-1
  // saturated at all ones without needing a wide shifter.
  always_comb begin
    be = '0;
    for (int i = 0; i < DW_B; i++) begin
      be[i] = (rem > REM_W'(i));
    end
  end

endmodule

// File: rtl/vl_beat_sequencer.sv
// Walks one vector operand in DATA_WIDTH-wide beats using the vl/vtype
// state captured at start, producing beat index, byte enables and a last
// flag for the register-file ports.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, avl, sew,     operand request and its configuration; sampled
//   vill                 and captured only in IDLE
//   flush                abort the operand in flight (no done/err)
//   out_valid/out_ready  beat handshake
//   out_idx/out_be/      beat index, byte enables, final-beat flag
//   out_last
//   busy                 not IDLE
//   done, err            one-cycle completion pulse; err marks a rejected
//                        operand (vill or avl==0)
//
// Handshake: a beat transfers on a cycle where out_valid && out_ready.
// While out_valid is high and out_ready low, out_idx/out_be/out_last hold;
// out_valid never drops without a transfer except on flush or rst.
module vl_beat_sequencer
  import vrvv_cfg_pkg::*;
#(
  parameter int VLEN        = 16384,
  parameter int DATA_WIDTH  = 64,
  parameter int VLMAX       = VLEN >> 3,
  parameter int VLEN_B_BITS = $clog2(VLMAX),
  localparam int DW_B       = dw_bytes(DATA_WIDTH),
  localparam int BEAT_BITS  = VLEN_B_BITS + 4 - $clog2(DW_B)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [VLEN_B_BITS-1:0] avl,
  input  logic [1:0]             sew,
  input  logic                   vill,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BEAT_BITS-1:0]   out_idx,
  output logic [DW_B-1:0]        out_be,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int LOG_DWB = $clog2(DW_B);
  localparam int TB_W    = VLEN_B_BITS + 4;
  localparam int NB_W    = BEAT_BITS + 1;

  seq_state_t           state_q, state_d;
  logic [BEAT_BITS-1:0] idx_q;
  logic [TB_W-1:0]      total_q;
  logic [NB_W-1:0]      nbeats_q;
  logic                 err_pending_q;

  logic                 load, inc, xfer, reject, is_last;
  logic [TB_W-1:0]      avl_ext, total_in, rem;
  logic [TB_W:0]        round_up;
  logic [NB_W-1:0]      nbeats_in;
  logic [DW_B-1:0]      be_raw;

  // Operand size in bytes; the 4 extra bits absorb the largest sew shift.
  assign avl_ext = TB_W'(avl);
  always_comb begin
    total_in = avl_ext;
    case (sew)
      SEW_8:   total_in = avl_ext;
      SEW_16:  total_in = avl_ext << 1;
      SEW_32:  total_in = avl_ext << 2;
      SEW_64:  total_in = avl_ext << 3;
      default: total_in = avl_ext;
    endcase
  end

  // ceil(total/DW_B); one guard bit keeps the round-up add from wrapping.
  assign round_up  = {1'b0, total_in} + (TB_W+1)'(DW_B - 1);
  assign nbeats_in = NB_W'(round_up >> LOG_DWB);
  assign reject    = vill || (avl == '0);

  assign xfer    = (state_q == RUN) && out_ready;
  assign is_last = ({1'b0, idx_q} == (nbeats_q - NB_W'(1)));
  // Cannot underflow in RUN: idx_q < nbeats_q.
  assign rem     = total_q - (TB_W'(idx_q) << LOG_DWB);

  be_mask_gen #(
    .DW_B  (DW_B),
    .REM_W (TB_W)
  ) u_be_mask_gen (
    .rem (rem),
    .be  (be_raw)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    inc     = 1'b0;
    case (state_q)
      IDLE: begin
        // flush has no meaning here, so a coincident start is honoured.
        if (start) begin
          load    = 1'b1;
          state_d = reject ? FIN : RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          if (is_last) state_d = FIN;
          else         inc     = 1'b1;
        end
        // A beat accepted this cycle still counts, but the operand ends.
        if (flush) state_d = IDLE;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      total_q       <= '0;
      nbeats_q      <= '0;
      err_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        total_q       <= total_in;
        nbeats_q      <= nbeats_in;
        err_pending_q <= reject;
      end
      if (load || state_d == IDLE) idx_q <= '0;
      else if (inc)                idx_q <= idx_q + BEAT_BITS'(1);
    end
  end

  assign out_valid = (state_q == RUN);
  assign out_idx   = idx_q;
  assign out_be    = out_valid ? be_raw : '0;
  assign out_last  = out_valid && is_last;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN) && !flush;
  assign err       = done && err_pending_q;

endmodule

// File: tb/tb_vl_beat_sequencer.sv
module tb_vl_beat_sequencer;

  localparam int AW        = 11;
  localparam int BEAT_BITS = 12;
  localparam int DW_B      = 8;
  localparam int EW        = BEAT_BITS + DW_B + 1;

  logic                 clk = 1'b0;
  logic                 rst, start, vill, flush, out_ready;
  logic [AW-1:0]        avl;
  logic [1:0]           sew;
  logic                 out_valid, out_last, busy, done, err;
  logic [BEAT_BITS-1:0] out_idx;
  logic [DW_B-1:0]      out_be;

  vl_beat_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .avl       (avl),
    .sew       (sew),
    .vill      (vill),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_be    (out_be),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- model / scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  int valid_cnt, xfer_cnt, last_xfer_cyc;

  function automatic logic [7:0] model_be(input int total, input int i);
    int r;
    r = total - 8 * i;
    if (r >= 8) return 8'hFF;
    return 8'((1 << r) - 1);
  endfunction

  task automatic push_op(input int a, input int s);
    int total, nb;
    total = a << s;
    nb    = (total + 7) / 8;
    for (int i = 0; i < nb; i++)
      exp_q.push_back({BEAT_BITS'(i), model_be(total, i), 1'(i == nb - 1)});
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      valid_cnt++;
      if (out_ready) begin
        xfer_cnt++;
        if (out_last) last_xfer_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_idx",  64'(out_idx),  64'(mon_e[EW-1 -: BEAT_BITS]));
          check("beat_be",   64'(out_be),   64'(mon_e[DW_B:1]));
          check("beat_last", 64'(out_last), 64'(mon_e[0]));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic do_start(input int a, input int s, input logic v, input logic fl);
    @(posedge clk); #1;
    start = 1'b1; avl = AW'(a); sew = 2'(s); vill = v; flush = fl;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    // Scramble config after capture; the operand must not notice.
    avl = AW'($urandom_range(0, 2047)); sew = 2'($urandom_range(0, 3));
    vill = 1'($urandom_range(0, 1));
  endtask

  task automatic run_op(input int a, input int s, input logic v, input int stall_idx,
                        input int stall_n, input logic poke, input logic fl);
    logic rejected, got_done;
    int total, nb, stalled;
    rejected = v || (a == 0);
    total    = a << s;
    nb       = (total + 7) / 8;
    if (!rejected) push_op(a, s);
    valid_cnt = 0; xfer_cnt = 0; got_done = 1'b0; stalled = 0;
    do_start(a, s, v, fl);
    for (int k = 0; k < 5000 && !got_done; k++) begin
      if (out_valid && out_idx == stall_idx && stalled < stall_n) begin
        out_ready = 1'b0; stalled++;
      end else begin
        out_ready = 1'b1;
      end
      start = poke && (k == 1);
      if (start) begin avl = AW'(5); sew = 2'd0; vill = 1'b0; end
      @(negedge clk);
      if (k == 0) begin
        check("first_valid", 64'(out_valid), 64'(!rejected));
        check("busy_run", 64'(busy), 64'd1);
      end
      if (!out_ready) begin
        check("stall_idx",  64'(out_idx),  64'(stall_idx));
        check("stall_be",   64'(out_be),   64'(model_be(total, stall_idx)));
        check("stall_last", 64'(out_last), 64'(stall_idx == nb - 1));
      end
      if (done) begin
        got_done = 1'b1;
        check("err", 64'(err), 64'(rejected));
        if (rejected) check("rej_latency", 64'(k), 64'd0);
        else          check("done_latency", 64'(cyc - last_xfer_cyc), 64'd1);
      end
      @(posedge clk); #1;
    end
    start = 1'b0; out_ready = 1'b1;
    if (!got_done) check("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    check("busy_after", 64'(busy), 64'd0);
    check("done_once",  64'(done), 64'd0);
    check("q_empty",    64'(exp_q.size()), 64'd0);
    check("xfers",      64'(xfer_cnt),  64'(rejected ? 0 : nb));
    check("valids",     64'(valid_cnt), 64'(rejected ? 0 : nb + stalled));
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_idx"},   64'(out_idx),   64'd0);
    check({tag, "_be"},    64'(out_be),    64'd0);
    check({tag, "_last"},  64'(out_last),  64'd0);
    check({tag, "_busy"},  64'(busy),      64'd0);
    check({tag, "_done"},  64'(done),      64'd0);
    check({tag, "_err"},   64'(err),       64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; avl = '0; sew = '0; vill = 1'b0; flush = 1'b0;
    out_ready = 1'b1;
    valid_cnt = 0; xfer_cnt = 0; last_xfer_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(20, 0, 1'b0, -1, 0, 1'b0, 1'b0);   // FF/FF/0F
    run_op(4,  2, 1'b0, -1, 0, 1'b0, 1'b0);   // FF/FF
    run_op(3,  3, 1'b0, -1, 0, 1'b0, 1'b0);   // 3 full beats
    run_op(1,  1, 1'b0, -1, 0, 1'b0, 1'b0);   // single beat 03
    run_op(20, 0, 1'b0, 1, 3, 1'b0, 1'b0);    // back-pressure on idx 1
    run_op(8,  0, 1'b1, -1, 0, 1'b0, 1'b0);   // vill
    run_op(0,  2, 1'b0, -1, 0, 1'b0, 1'b0);   // avl == 0
    run_op(20, 0, 1'b0, -1, 0, 1'b1, 1'b0);   // start during RUN ignored
    run_op(9,  1, 1'b0, -1, 0, 1'b0, 1'b1);   // flush with start in IDLE

    // flush on the idx-1 transfer of a 3-beat operand
    push_op(20, 0);
    void'(exp_q.pop_back());
    do_start(20, 0, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    check("fl_valid0", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_busy",  64'(busy),      64'd0);
    check("fl_done",  64'(done),      64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fl_no_done", 64'(done), 64'd0);
    end
    check("fl_q_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    run_op(20, 0, 1'b0, -1, 0, 1'b0, 1'b0);

    // reset in the middle of RUN at idx 1
    push_op(20, 0);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    do_start(20, 0, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_idx", 64'(out_idx), 64'd1);
    @(negedge clk);
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_done", 64'(done), 64'd0);
    end
    check("rst_q_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    run_op(20, 0, 1'b0, -1, 0, 1'b0, 1'b0);

    // random operands, including random stalls
    for (int i = 0; i < 6; i++)
      run_op($urandom_range(1, 40), $urandom_range(0, 3), 1'b0,
             $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, 1'b0);

    // largest representable operand: 2047 x 64-bit elements
    run_op(2047, 3, 1'b0, 100, 2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
